// File: rtl/rx_link_pkg.sv
// Shared definitions for the receive link monitor: channel FSM states,
// counter-select codes and the bit order within each {err,ok} CRC pair.
package rx_link_pkg;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_RECV     = 2'd1,
      ST_CRC_WAIT = 2'd2
   } chan_state_t;

   localparam int NUM_CNT = 4;

   localparam logic [1:0] SEL_OK      = 2'd0;
   localparam logic [1:0] SEL_CRC_ERR = 2'd1;
   localparam logic [1:0] SEL_TIMEOUT = 2'd2;
   localparam logic [1:0] SEL_ABORT   = 2'd3;

   localparam int CRC_OK_BIT  = 0;
   localparam int CRC_ERR_BIT = 1;

endpackage

// File: rtl/rx_link_chan.sv
// One receive channel: frame FSM with watchdog timer and four saturating
// statistics counters (ok, crc_err, timeout, abort).
module rx_link_chan
   import rx_link_pkg::*;
#(
   parameter int CNT_W        = 16,
   parameter int TMO_W        = 16,
   parameter int TMO_CYC      = 4000,
   parameter int CRC_WAIT_CYC = 8
) (
   input  logic                            sys_clk,
   input  logic                            rst,
   input  logic                            start_evt,
   input  logic                            done_evt,
   input  logic                            crc_ok_evt,
   input  logic                            crc_err_evt,
   input  logic                            cnt_clr,
   output logic                            busy,
   output logic                            timeout,
   output logic [NUM_CNT-1:0][CNT_W-1:0]   cnt
);

   localparam logic [TMO_W-1:0] RECV_LAST = TMO_W'(TMO_CYC - 1);
   localparam logic [TMO_W-1:0] WAIT_LAST = TMO_W'(CRC_WAIT_CYC - 1);

   chan_state_t        state_q;
   logic [TMO_W-1:0]   timer_q;
   logic [NUM_CNT-1:0] inc;
   logic               crc_evt;
   logic [1:0]         crc_sel;

   assign crc_evt = crc_ok_evt | crc_err_evt;
   // Both CRC bits together count as an error.
   assign crc_sel = (crc_ok_evt && !crc_err_evt) ? SEL_OK : SEL_CRC_ERR;
   assign busy    = (state_q != ST_IDLE);

   // Counter increments, with start taking priority over done/CRC over expiry.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path infers a latch.
      inc = '0;
      case (state_q)
         ST_RECV: begin
            if (start_evt)                           inc[SEL_ABORT]   = 1'b1;
            else if (done_evt && crc_evt)            inc[crc_sel]     = 1'b1;
            else if (!done_evt && timer_q == RECV_LAST) inc[SEL_TIMEOUT] = 1'b1;
         end
         ST_CRC_WAIT: begin
            if (start_evt)                           inc[SEL_ABORT]   = 1'b1;
            else if (crc_evt)                        inc[crc_sel]     = 1'b1;
            else if (timer_q == WAIT_LAST)           inc[SEL_TIMEOUT] = 1'b1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge sys_clk) begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      if (rst) begin
         state_q <= ST_IDLE;
         timer_q <= '0;
         timeout <= 1'b0;
      end else begin
         timeout <= inc[SEL_TIMEOUT];
         timer_q <= timer_q + 1'b1;
         case (state_q)
            ST_IDLE: begin
               timer_q <= '0;
               if (start_evt) state_q <= ST_RECV;
            end
            ST_RECV: begin
               if (start_evt) begin
                  timer_q <= '0;
               end else if (done_evt) begin
                  timer_q <= '0;
                  state_q <= crc_evt ? ST_IDLE : ST_CRC_WAIT;
               end else if (inc[SEL_TIMEOUT]) begin
                  state_q <= ST_IDLE;
               end
            end
            ST_CRC_WAIT: begin
               if (start_evt) begin
                  timer_q <= '0;
                  state_q <= ST_RECV;
               end else if (crc_evt || inc[SEL_TIMEOUT]) begin
                  state_q <= ST_IDLE;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge sys_clk) begin
      if (rst || cnt_clr) begin
         cnt <= '0;
      end else begin
         for (int i = 0; i < NUM_CNT; i++)
            if (inc[i] && cnt[i] != '1) cnt[i] <= cnt[i] + 1'b1;
      end
   end

endmodule

// File: rtl/rx_link_mon.sv
// Receive link monitor: synchronises stretched per-channel level inputs into
// one-cycle event pulses and feeds per-channel frame FSMs with a counter read port.
module rx_link_mon
   import rx_link_pkg::*;
#(
   parameter int CH_NUM       = 2,
   parameter int SYNC_STAGES  = 2,
   parameter int CNT_W        = 16,
   parameter int TMO_W        = 16,
   parameter int TMO_CYC      = 4000,
   parameter int CRC_WAIT_CYC = 8
) (
   input  logic                  sys_clk,
   input  logic                  rst,
   input  logic [CH_NUM-1:0]     rx_start_lvl,
   input  logic [CH_NUM-1:0]     rx_done_lvl,
   input  logic [2*CH_NUM-1:0]   rx_crc_lvl,
   input  logic                  cnt_clr,
   input  logic                  cnt_rd_en,
   input  logic [2:0]            cnt_rd_ch,
   input  logic [1:0]            cnt_rd_sel,
   output logic [CNT_W-1:0]      cnt_rd_data,
   output logic [CH_NUM-1:0]     o_rx_start,
   output logic [CH_NUM-1:0]     o_rx_done,
   output logic [2*CH_NUM-1:0]   o_rx_crc_rslt,
   output logic [CH_NUM-1:0]     o_rx_timeout,
   output logic [CH_NUM-1:0]     o_busy
);

   localparam int NB     = 4 * CH_NUM;
   localparam int SETTLE = SYNC_STAGES + 2;

   logic [NB-1:0]                             lvl;
   logic [SYNC_STAGES-1:0][NB-1:0]            sync_q;
   logic [NB-1:0]                             det_q, det_d, evt, evt_q;
   logic [2:0]                                settle_q;
   logic                                      settled;
   logic [CH_NUM-1:0][NUM_CNT-1:0][CNT_W-1:0] cnt_all;
   logic [CNT_W-1:0]                          rd_mux;

   assign lvl     = {rx_crc_lvl, rx_done_lvl, rx_start_lvl};
   // Edges are masked until the pipeline holds only post-reset samples, so a
   // level that stayed high across reset never looks like a fresh rise.
   assign settled = (settle_q == 3'(SETTLE));
   assign evt     = settled ? (det_q & ~det_d) : '0;

   always_ff @(posedge sys_clk) begin
      if (rst) begin
         sync_q   <= '0;
         det_q    <= '0;
         det_d    <= '0;
         evt_q    <= '0;
         settle_q <= '0;
      end else begin
         sync_q[0] <= lvl;
         for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
         det_q <= sync_q[SYNC_STAGES-1];
         det_d <= det_q;
         evt_q <= evt;
         if (!settled) settle_q <= settle_q + 3'd1;
      end
   end

   assign o_rx_start    = evt_q[CH_NUM-1:0];
   assign o_rx_done     = evt_q[2*CH_NUM-1:CH_NUM];
   assign o_rx_crc_rslt = evt_q[NB-1:2*CH_NUM];

   for (genvar c = 0; c < CH_NUM; c++) begin : g_chan
      rx_link_chan #(
         .CNT_W        (CNT_W),
         .TMO_W        (TMO_W),
         .TMO_CYC      (TMO_CYC),
         .CRC_WAIT_CYC (CRC_WAIT_CYC)
      ) u_chan (
         .sys_clk     (sys_clk),
         .rst         (rst),
         .start_evt   (evt[c]),
         .done_evt    (evt[CH_NUM+c]),
         .crc_ok_evt  (evt[2*CH_NUM+2*c+CRC_OK_BIT]),
         .crc_err_evt (evt[2*CH_NUM+2*c+CRC_ERR_BIT]),
         .cnt_clr     (cnt_clr),
         .busy        (o_busy[c]),
         .timeout     (o_rx_timeout[c]),
         .cnt         (cnt_all[c])
      );
   end

   always_comb begin
      rd_mux = '0;
      for (int c = 0; c < CH_NUM; c++)
         if (cnt_rd_ch == 3'(c)) rd_mux = cnt_all[c][cnt_rd_sel];
   end

   always_ff @(posedge sys_clk) begin
      if (rst)            cnt_rd_data <= '0;
      else if (cnt_rd_en) cnt_rd_data <= rd_mux;
   end

endmodule
